// File: rtl/opcode_encoder.sv
// Packs a one-hot opcode word into an 8-bit instruction byte and streams it with
// sequential program addresses through a 2-entry buffer. Optional: OPENC_ERR_CNT_EN adds err_cnt.
module opcode_encoder #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [26:0]   in_opcode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_instr,
  output logic [AW-1:0] out_addr,
  output logic          err_flag,
  input  logic          err_clr
`ifdef OPENC_ERR_CNT_EN
  ,
  output logic [7:0]    err_cnt
`endif
);

  // Handshakes: a transfer happens on a cycle where valid && ready; valid never
  // waits for ready, and in_ready depends only on registered buffer occupancy.

  logic [1:0]    r_count;
  logic          r_rd_ptr;
  logic          r_wr_ptr;
  logic [7:0]    r_mem [2];
  logic [AW-1:0] r_addr;
  logic          r_err_flag;

  logic [22:0]   w_hot;
  logic [22:0]   w_hot_low_cleared;
  logic          w_legal;
  logic [4:0]    w_hot_idx;
  logic [4:0]    w_idx_g1;
  logic [4:0]    w_idx_g15;
  logic [3:0]    w_upper;
  logic [3:0]    w_lower;
  logic [7:0]    w_instr;
  logic          w_accept;
  logic          w_push;
  logic          w_illegal;
  logic          w_pop;

  assign w_hot             = in_opcode[22:0];
  assign w_hot_low_cleared = w_hot & (w_hot - 23'd1);
  assign w_legal           = (w_hot != 23'd0) && (w_hot_low_cleared == 23'd0);

  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign out_instr = out_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign out_addr  = r_addr;
  assign err_flag  = r_err_flag;

  assign w_accept  = in_valid && in_ready;
  assign w_push    = w_accept && w_legal;
  assign w_illegal = w_accept && !w_legal;
  assign w_pop     = out_valid && out_ready;

  // Index of the hot bit; only meaningful for legal words.
  always_comb begin
    w_hot_idx = 5'd0;
    for (int k = 0; k < 23; k++) begin
      if (w_hot[k]) w_hot_idx = 5'(k);
    end
  end

  assign w_idx_g1  = w_hot_idx - 5'd1;
  assign w_idx_g15 = w_hot_idx - 5'd19;

  always_comb begin
    w_upper = 4'd0;
    w_lower = {in_opcode[26:25], in_opcode[24:23]};
    if (w_hot_idx == 5'd0) begin
      w_upper = 4'd0;
    end else if (w_hot_idx <= 5'd4) begin
      w_upper = 4'd1;
      w_lower = {in_opcode[26:25], w_idx_g1[1:0]};
    end else if (w_hot_idx <= 5'd14) begin
      w_upper = 4'(w_hot_idx - 5'd3);
    end else if (w_hot_idx <= 5'd16) begin
      w_upper = 4'd12;
      w_lower = {in_opcode[26:25], in_opcode[24], in_opcode[16]};
    end else if (w_hot_idx == 5'd17) begin
      w_upper = 4'd13;
    end else if (w_hot_idx == 5'd18) begin
      w_upper = 4'd14;
    end else begin
      w_upper = 4'd15;
      w_lower = {in_opcode[26:25], w_idx_g15[1:0]};
    end
  end

  assign w_instr = {w_upper, w_lower};

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_instr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= 2'd0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_addr   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
        r_addr   <= r_addr + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A new error outranks a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_flag <= 1'b0;
    end else if (w_illegal) begin
      r_err_flag <= 1'b1;
    end else if (err_clr) begin
      r_err_flag <= 1'b0;
    end
  end

`ifdef OPENC_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= 8'd0;
    end else if (err_clr) begin
      r_err_cnt <= w_illegal ? 8'd1 : 8'd0;
    end else if (w_illegal && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_opcode_encoder.sv
// Bench for opcode_encoder: table of hand-encoded opcode words, a cycle model of the
// buffer/address/error state, and an expected-byte queue checked at the buffer head.
module tb_opcode_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready, in_ready2;
  logic [26:0] in_opcode;
  logic        out_valid, out_valid2;
  logic        out_ready;
  logic [7:0]  out_instr, out_instr2;
  logic [7:0]  out_addr;
  logic [1:0]  out_addr2;
  logic        err_flag, err_flag2;
  logic        err_clr;
`ifdef OPENC_ERR_CNT_EN
  logic [7:0]  err_cnt, err_cnt2;
`endif

  always #5 clk = ~clk;

  opcode_encoder #(.AW(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .err_flag(err_flag),
    .err_clr(err_clr)
`ifdef OPENC_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  opcode_encoder #(.AW(2)) u_dut_aw2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_opcode(in_opcode), .out_valid(out_valid2), .out_ready(out_ready),
    .out_instr(out_instr2), .out_addr(out_addr2), .err_flag(err_flag2),
    .err_clr(err_clr)
`ifdef OPENC_ERR_CNT_EN
    , .err_cnt(err_cnt2)
`endif
  );

  typedef struct {
    logic [26:0] op;
    logic [7:0]  exp;
    logic        legal;
  } vec_t;

  vec_t       vecs[$];
  vec_t       stim_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_addr;
  logic       m_err;
  int         m_ecnt;
  int         n_cmp = 0;
  int         n_bad = 0;

  function automatic logic [26:0] mk(input int b, input logic [1:0] a, input logic [1:0] bb);
    logic [22:0] h;
    h = 23'd1 << b;
    return {a, bb, h};
  endfunction

  function automatic vec_t mkv(input logic [26:0] op, input logic [7:0] exp, input logic legal);
    vec_t v;
    v.op = op; v.exp = exp; v.legal = legal;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: drive, compare registered outputs, step model across posedge.
  task automatic cycle();
    bit acc, pop;
    vec_t it;
    in_valid  = (stim_q.size() > 0);
    in_opcode = in_valid ? stim_q[0].op : 27'd0;
    if (!rst) begin
      chk("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) chk("out_instr", 32'(out_instr), 32'(exp_q[0]));
      chk("out_addr", 32'(out_addr), 32'(m_addr));
      chk("err_flag", 32'(err_flag), 32'(m_err));
      chk("aw2_out_addr", 32'(out_addr2), 32'(m_addr[1:0]));
      chk("aw2_in_ready", 32'(in_ready2), 32'(exp_q.size() < 2));
      if (exp_q.size() > 0) chk("aw2_out_instr", 32'(out_instr2), 32'(exp_q[0]));
`ifdef OPENC_ERR_CNT_EN
      chk("err_cnt", 32'(err_cnt), 32'(m_ecnt));
`endif
    end
    acc = in_valid && (exp_q.size() < 2) && !rst;
    pop = (exp_q.size() > 0) && out_ready && !rst;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_addr = 8'd0;
      m_err  = 1'b0;
      m_ecnt = 0;
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        m_addr = m_addr + 8'd1;
      end
      if (acc) begin
        it = stim_q.pop_front();
        if (it.legal) exp_q.push_back(it.exp);
        else begin
          m_err  = 1'b1;
          m_ecnt = err_clr ? 1 : ((m_ecnt < 255) ? m_ecnt + 1 : 255);
        end
      end else if (err_clr) begin
        m_err  = 1'b0;
        m_ecnt = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic drain(input int budget);
    int b;
    b = budget;
    while ((stim_q.size() > 0 || exp_q.size() > 0) && b > 0) begin
      cycle();
      b--;
    end
    if (b == 0) chk("drain_timeout", 32'(stim_q.size() + exp_q.size()), 32'd0);
  endtask

  initial begin
    vecs.push_back(mkv(mk(0, 2'd2, 2'd2), 8'h0A, 1'b1));
    vecs.push_back(mkv(mk(3, 2'd0, 2'd0), 8'h12, 1'b1));
    vecs.push_back(mkv(mk(7, 2'd1, 2'd2), 8'h46, 1'b1));
    vecs.push_back(mkv(mk(16, 2'd0, 2'd2), 8'hC3, 1'b1));
    vecs.push_back(mkv(mk(22, 2'd0, 2'd1), 8'hF3, 1'b1));
    vecs.push_back(mkv(mk(15, 2'd3, 2'd1), 8'hCC, 1'b1));
    vecs.push_back(mkv(mk(1, 2'd1, 2'd3), 8'h14, 1'b1));
    vecs.push_back(mkv(mk(4, 2'd2, 2'd0), 8'h1B, 1'b1));
    vecs.push_back(mkv(mk(5, 2'd0, 2'd3), 8'h23, 1'b1));
    vecs.push_back(mkv(mk(14, 2'd1, 2'd1), 8'hB5, 1'b1));
    vecs.push_back(mkv(mk(17, 2'd2, 2'd3), 8'hDB, 1'b1));
    vecs.push_back(mkv(mk(18, 2'd0, 2'd0), 8'hE0, 1'b1));
    vecs.push_back(mkv(mk(19, 2'd3, 2'd2), 8'hFC, 1'b1));
    vecs.push_back(mkv(mk(20, 2'd1, 2'd0), 8'hF5, 1'b1));
    vecs.push_back(mkv(mk(21, 2'd2, 2'd1), 8'hFA, 1'b1));
    vecs.push_back(mkv(mk(10, 2'd0, 2'd0), 8'h70, 1'b1));
    vecs.push_back(mkv(27'd0, 8'h00, 1'b0));
    vecs.push_back(mkv(mk(5, 2'd0, 2'd0) | mk(6, 2'd0, 2'd0), 8'h00, 1'b0));

    rst = 1'b1; in_valid = 1'b0; in_opcode = 27'd0; out_ready = 1'b0; err_clr = 1'b0;
    m_addr = 8'd0; m_err = 1'b0; m_ecnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", 32'(out_instr), 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_err_flag", 32'(err_flag), 32'd0);

    // First byte: one-cycle latency, address 0.
    stim_q.push_back(vecs[0]);
    cycle();
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_instr", 32'(out_instr), 32'h0A);
    chk("first_addr", 32'(out_addr), 32'd0);
    out_ready = 1'b1;
    drain(20);

    // Whole table streamed back to back with memory always ready.
    foreach (vecs[i]) stim_q.push_back(vecs[i]);
    drain(100);

    // Random back-pressure over random table entries.
    for (int i = 0; i < 80; i++) stim_q.push_back(vecs[$urandom_range(0, vecs.size() - 1)]);
    for (int b = 0; b < 600 && (stim_q.size() > 0 || exp_q.size() > 0); b++) begin
      out_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    out_ready = 1'b1;
    drain(50);

    // Full buffer: third word must wait, head held while stalled.
    out_ready = 1'b0;
    stim_q.push_back(vecs[2]); stim_q.push_back(vecs[3]); stim_q.push_back(vecs[4]);
    run(5);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_head", 32'(out_instr), 32'h46);
    out_ready = 1'b1;
    drain(20);

    // Illegal words, clear, then clear colliding with a new error.
    stim_q.push_back(vecs[16]); stim_q.push_back(vecs[17]);
    drain(20);
    chk("err_set", 32'(err_flag), 32'd1);
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    run(1);
    chk("err_cleared", 32'(err_flag), 32'd0);
    stim_q.push_back(vecs[16]);
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    run(2);
    chk("err_clr_collide", 32'(err_flag), 32'd1);
`ifdef OPENC_ERR_CNT_EN
    for (int i = 0; i < 260; i++) stim_q.push_back(vecs[17]);
    drain(300);
    chk("err_cnt_sat", 32'(err_cnt), 32'd255);
`endif

    // Reset with two bytes buffered.
    out_ready = 1'b0;
    stim_q.push_back(vecs[5]); stim_q.push_back(vecs[6]);
    run(3);
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_addr", 32'(out_addr), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) stim_q.push_back(vecs[i]);
    drain(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
